// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht
// Direct-mapped table of saturating counters indexed by fetch PC. Predicts
// conditional branches in IF, computes the B-type target, trains on resolution
// in EX/MEM, drives next-PC / flush and keeps resolve/mispredict statistics.
//
// Optional feature: define BP_GSHARE_EN to XOR an IDX_W-bit global history
// register into the lookup index (gshare). Training always uses the index that
// was carried down the pipeline, so it hits the entry that made the prediction.
//
// Handshake note: there is no valid/ready flow control here. A lookup is
// performed every cycle on pc_value/im_instruction; a resolution is consumed on
// every rising edge where ex_mem_branch = 1 and ignored otherwise.
module branch_predictor_bht #(
  parameter int ADDR_W  = 64,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 32,
  localparam int IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic              systemClock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_value,
  input  logic [31:0]       im_instruction,
  input  logic              ex_mem_branch,
  input  logic              ex_mem_taken,
  input  logic              ex_mem_prediction,
  input  logic [IDX_W-1:0]  ex_mem_index,
  input  logic [ADDR_W-1:0] ex_mem_pc_value,
  input  logic [ADDR_W-1:0] ex_mem_pc_plus_immediate,
  output logic [ADDR_W-1:0] pc_new_value,
  output logic              pred_prediction,
  output logic [IDX_W-1:0]  pred_index,
  output logic              pred_flush,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam logic [6:0]        OPC_BRANCH = 7'b1100011;
  localparam int unsigned       CTR_RST_I  = (1 << (CTR_W - 1)) - 1;
  localparam logic [CTR_W-1:0]  CTR_RST    = CTR_W'(CTR_RST_I);
  localparam logic [CTR_W-1:0]  CTR_MAX    = '1;
  localparam logic [CTR_W-1:0]  CTR_MIN    = '0;
  localparam logic [STAT_W-1:0] STAT_MAX   = '1;

  // Counter table and statistics state
  logic [CTR_W-1:0]  ctr_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_cur;
  logic [CTR_W-1:0]  ctr_next;
  logic [STAT_W-1:0] br_cnt_q;
  logic [STAT_W-1:0] mis_cnt_q;

  // Lookup / redirect intermediates
  logic [IDX_W-1:0]  pc_idx;
  logic              is_br;
  logic              pred_raw;
  logic              mis_raw;
  logic              mis;
  logic [ADDR_W-1:0] b_imm;
  logic [ADDR_W-1:0] b_target;

  // Instruction bits 24:12 (rs1/rs2/funct3) play no part in prediction.
  logic unused_instr_bits;
  assign unused_instr_bits = ^im_instruction[24:12];

  assign pc_idx = pc_value[IDX_W+1:2];

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;
  logic [IDX_W-1:0] ghr_next;

  // Shift the resolved outcome into the history (oldest bit falls off the top)
  if (IDX_W == 1) begin : g_ghr_one
    assign ghr_next = ex_mem_taken;
  end else begin : g_ghr_many
    assign ghr_next = {ghr_q[IDX_W-2:0], ex_mem_taken};
  end

  // Global history register, advanced once per resolved branch
  always_ff @(posedge systemClock or negedge reset) begin
    if (!reset) begin
      ghr_q <= '0;
    end else if (ex_mem_branch) begin
      ghr_q <= ghr_next;
    end
  end

  assign pred_index = pc_idx ^ ghr_q;
`else
  assign pred_index = pc_idx;
`endif

  // B-type immediate: {imm[12], imm[11], imm[10:5], imm[4:1], 0}, sign-extended
  assign b_imm = {{(ADDR_W-12){im_instruction[31]}},
                  im_instruction[7], im_instruction[30:25],
                  im_instruction[11:8], 1'b0};
  assign b_target = pc_value + b_imm;

  // Combinational lookup; table read is before any same-cycle write.
  assign is_br    = (im_instruction[6:0] == OPC_BRANCH);
  assign pred_raw = is_br & ctr_q[pred_index][CTR_W-1];
  assign mis_raw  = ex_mem_branch & (ex_mem_taken != ex_mem_prediction);

  // While in reset the prediction and flush are held low; the rest follows inputs.
  assign pred_prediction = reset & pred_raw;
  assign mis             = reset & mis_raw;
  assign pred_flush      = mis;

  // Next-PC select: resolution redirect beats IF prediction beats sequential
  always_comb begin
    pc_new_value = pc_value + ADDR_W'(4);
    if (mis && ex_mem_taken) begin
      pc_new_value = ex_mem_pc_plus_immediate;
    end else if (mis) begin
      pc_new_value = ex_mem_pc_value + ADDR_W'(4);
    end else if (pred_prediction) begin
      pc_new_value = b_target;
    end
  end

  // Saturating counter step for the entry being trained
  always_comb begin
    ctr_cur  = ctr_q[ex_mem_index];
    ctr_next = ctr_cur;
    if (ex_mem_taken) begin
      if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + CTR_W'(1);
    end else begin
      if (ctr_cur != CTR_MIN) ctr_next = ctr_cur - CTR_W'(1);
    end
  end

  // Counter table: reset to weakly not-taken, train on each resolved branch
  always_ff @(posedge systemClock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_RST;
      end
    end else if (ex_mem_branch) begin
      ctr_q[ex_mem_index] <= ctr_next;
    end
  end

  // Saturating statistics for resolved branches and mispredicts
  always_ff @(posedge systemClock or negedge reset) begin
    if (!reset) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (ex_mem_branch) begin
      if (br_cnt_q != STAT_MAX) br_cnt_q <= br_cnt_q + STAT_W'(1);
      if (mis && (mis_cnt_q != STAT_MAX)) mis_cnt_q <= mis_cnt_q + STAT_W'(1);
    end
  end

  assign stat_branches    = br_cnt_q;
  assign stat_mispredicts = mis_cnt_q;

endmodule
